bus_load_unit: RTL and testbench
================================

Name: bus_load_unit

Overview:
- Destination side of the 8-bit common bus: latches the bus value into the selected registers (AR, PC, DR, AC, IR) and into a 16x8 RAM.
- Also owns the 3-bit sequence counter (SC) that steps the control timing.
- Register and RAM outputs feed the bus source selector, closing the transfer loop.
- A bus source select plus one or more load enables completes one register transfer per clock.

Parameters:
- DATA_W, 8, common bus and DR/AC/IR/RAM word width.
- ADDR_W, 4, AR/PC width and RAM address width (RAM depth = 2**ADDR_W).
- SC_W, 3, sequence counter width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- bus  in  DATA_W  common bus value
- ld_ar, ld_pc, ld_dr, ld_ac, ld_ir  in  1 each  load register from bus
- inc_ar, inc_pc, inc_dr, inc_ac  in  1 each  increment register
- clr_ar, clr_pc, clr_ac  in  1 each  clear register
- mem_wr  in  1  write bus into RAM[AR]
- sc_inc, sc_clr  in  1 each  sequence counter control
- ar, pc  out  ADDR_W  address / program counter
- dr, ac, ir  out  DATA_W  data, accumulator, instruction registers
- ram_q  out  DATA_W  RAM[ar], combinational read
- sc  out  SC_W  sequence counter
- t  out  2**SC_W  one-hot decode of sc (t[sc] = 1)

Behaviour:
- **Reset (rst_n = 0, asynchronous):**
  - ar, pc, dr, ac, ir, sc = 0; t = 1 (T0).
  - All RAM words cleared to 0.
  - Reset wins over every control input; any pending write is discarded.
  - Deassertion takes effect at the next rising edge.
- **Register priority on each clock edge, per register:** clr > ld > inc > hold.
  - DR and IR have no clr. IR has no inc.
- **Load width rules:**
  - AR and PC load bus[ADDR_W-1:0]; upper bus bits are ignored.
  - DR, AC and IR load the full bus.
- **Increment:** modulo 2**width, wrapping silently (ar/pc F->0, dr/ac FF->00). No carry or flag output.
- **Multiple destinations:** any number of ld_* may be asserted in the same cycle. All of them capture the same bus value.
- **RAM:**
  - Write is synchronous: on a clock edge with mem_wr = 1, RAM[ar] <= bus, using the ar value held before that edge.
  - If ld_ar or inc_ar is asserted in the same cycle, the write still uses the old ar.
  - Read is asynchronous: ram_q = RAM[ar]. After a write, ram_q reflects the new data once ar and the edge have settled. There is no read latency.
- **Read-during-write:** in the cycle mem_wr is high, ram_q shows the old contents. From the edge onward it shows the new contents, provided ar is unchanged.
- **Sequence counter:**
  - sc_clr > sc_inc > hold.
  - sc_inc wraps 7 -> 0.
  - t is a pure decode of sc and always exactly one-hot.
- **Register latency:** all register outputs update on the same edge as their control. One cycle from control assertion to visible output.
- **Undefined control (X/Z):** not required to be handled. The verification bench drives only 0/1.

Test Plan:
- Reset mid-operation: load ac = 8'h5A, sc = 3, RAM[2] = 8'h11; pulse rst_n low between clock edges. Immediately ac = 0, sc = 0, t = 8'b0000_0001, and ram_q at ar = 2 reads 0.
- Bus truncation plus multi-load: bus = 8'hA7 with ld_ar, ld_pc, ld_dr, ld_ir for one cycle. Next cycle ar = 4'h7, pc = 4'h7, dr = 8'hA7, ir = 8'hA7; ac unchanged.
- Priority and wrap:
  - pc = 4'hF with inc_pc gives pc = 0.
  - ld_pc (bus = 8'h03) and inc_pc together give pc = 3.
  - clr_ac, ld_ac (bus = 8'h44) and inc_ac together give ac = 0.
  - ac = 8'hFF with inc_ac gives ac = 8'h00.
- RAM write with AR change: ar = 5, bus = 8'hC3, mem_wr and inc_ar together. Result: RAM[5] = 8'hC3, ar = 6. Then ld_ar with bus = 8'h05 gives ram_q = 8'hC3.
- Fetch sequence (T0: ld_ar from pc; T1: ld_ir from ram_q, inc_pc; T2: sc_clr), run from pc = 2 with RAM[2] = 8'h9B:
  - After 3 cycles: ir = 8'h9B, pc = 3, sc = 0.
  - t steps 1 -> 2 -> 4 -> 1.
- SC wrap: eight consecutive sc_inc give sc 0 -> 7 -> 0, with t one-hot every cycle. sc_clr and sc_inc together give sc = 0.

Source files
------------

// File: rtl/bus_load_unit_if.sv
// Common-bus destination interface: bus value and load/step controls in,
// register, RAM-read and sequence-timing values out.
interface bus_load_unit_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int SC_W   = 3
);
   logic [DATA_W-1:0]    bus;
   logic                 ld_ar, ld_pc, ld_dr, ld_ac, ld_ir;
   logic                 inc_ar, inc_pc, inc_dr, inc_ac;
   logic                 clr_ar, clr_pc, clr_ac;
   logic                 mem_wr;
   logic                 sc_inc, sc_clr;
   logic [ADDR_W-1:0]    ar, pc;
   logic [DATA_W-1:0]    dr, ac, ir;
   logic [DATA_W-1:0]    ram_q;
   logic [SC_W-1:0]      sc;
   logic [(2**SC_W)-1:0] t;

   // Controls are single-cycle level commands sampled on each rising edge;
   // there is no valid/ready handshake, every edge completes one transfer.
   modport master (
      output bus, ld_ar, ld_pc, ld_dr, ld_ac, ld_ir,
             inc_ar, inc_pc, inc_dr, inc_ac, clr_ar, clr_pc, clr_ac,
             mem_wr, sc_inc, sc_clr,
      input  ar, pc, dr, ac, ir, ram_q, sc, t
   );

   modport slave (
      input  bus, ld_ar, ld_pc, ld_dr, ld_ac, ld_ir,
             inc_ar, inc_pc, inc_dr, inc_ac, clr_ar, clr_pc, clr_ac,
             mem_wr, sc_inc, sc_clr,
      output ar, pc, dr, ac, ir, ram_q, sc, t
   );
endinterface

// File: rtl/bus_load_unit.sv
// Bus destination registers (AR, PC, DR, AC, IR), 16x8 RAM with async read,
// and the sequence counter with its one-hot timing decode.
module bus_load_unit #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int SC_W   = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   bus_load_unit_if.slave  bif
);
   localparam int DEPTH = 2**ADDR_W;
   localparam int T_W   = 2**SC_W;

   logic [ADDR_W-1:0] ar_q, ar_d, pc_q, pc_d;
   logic [DATA_W-1:0] dr_q, dr_d, ac_q, ac_d, ir_q, ir_d;
   logic [SC_W-1:0]   sc_q, sc_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [T_W-1:0]    t_dec;

   // Per register: clear beats load beats increment beats hold.
   always_comb begin
      ar_d = ar_q;
      if (bif.clr_ar)      ar_d = '0;
      else if (bif.ld_ar)  ar_d = bif.bus[ADDR_W-1:0];
      else if (bif.inc_ar) ar_d = ar_q + ADDR_W'(1);

      pc_d = pc_q;
      if (bif.clr_pc)      pc_d = '0;
      else if (bif.ld_pc)  pc_d = bif.bus[ADDR_W-1:0];
      else if (bif.inc_pc) pc_d = pc_q + ADDR_W'(1);

      dr_d = dr_q;
      if (bif.ld_dr)       dr_d = bif.bus;
      else if (bif.inc_dr) dr_d = dr_q + DATA_W'(1);

      ac_d = ac_q;
      if (bif.clr_ac)      ac_d = '0;
      else if (bif.ld_ac)  ac_d = bif.bus;
      else if (bif.inc_ac) ac_d = ac_q + DATA_W'(1);

      ir_d = ir_q;
      if (bif.ld_ir)       ir_d = bif.bus;

      sc_d = sc_q;
      if (bif.sc_clr)      sc_d = '0;
      else if (bif.sc_inc) sc_d = sc_q + SC_W'(1);
   end

   // Write address is the pre-edge AR, even when AR changes on the same edge.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
      if (bif.mem_wr) mem_d[ar_q] = bif.bus;
   end

   always_comb begin
      t_dec = '0;
      t_dec[sc_q] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ar_q <= '0;
         pc_q <= '0;
         dr_q <= '0;
         ac_q <= '0;
         ir_q <= '0;
         sc_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         ar_q <= ar_d;
         pc_q <= pc_d;
         dr_q <= dr_d;
         ac_q <= ac_d;
         ir_q <= ir_d;
         sc_q <= sc_d;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      end
   end

   assign bif.ar    = ar_q;
   assign bif.pc    = pc_q;
   assign bif.dr    = dr_q;
   assign bif.ac    = ac_q;
   assign bif.ir    = ir_q;
   assign bif.sc    = sc_q;
   assign bif.t     = t_dec;
   assign bif.ram_q = mem_q[ar_q];
endmodule

// File: tb/tb_bus_load_unit.sv
// Directed bench for bus_load_unit: reset, multi-load, priority/wrap, RAM
// write addressing, a fetch sequence and sequence-counter wrap.
module tb_bus_load_unit;
   logic clk;
   logic rst_n;
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   bus_load_unit_if bif ();

   bus_load_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bif   (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic idle();
      bif.bus = '0;
      bif.ld_ar = 0; bif.ld_pc = 0; bif.ld_dr = 0; bif.ld_ac = 0; bif.ld_ir = 0;
      bif.inc_ar = 0; bif.inc_pc = 0; bif.inc_dr = 0; bif.inc_ac = 0;
      bif.clr_ar = 0; bif.clr_pc = 0; bif.clr_ac = 0;
      bif.mem_wr = 0; bif.sc_inc = 0; bif.sc_clr = 0;
   endtask

   // Advance one edge, then release all controls away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
      idle();
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      check("rst_ar", bif.ar, 0);
      check("rst_pc", bif.pc, 0);
      check("rst_dr", bif.dr, 0);
      check("rst_ac", bif.ac, 0);
      check("rst_ir", bif.ir, 0);
      check("rst_sc", bif.sc, 0);
      check("rst_t", bif.t, 8'h01);
      check("rst_ram", bif.ram_q, 0);

      // Reset mid-operation
      bif.bus = 8'h5A; bif.ld_ac = 1; bif.sc_inc = 1; step();
      bif.sc_inc = 1; step();
      bif.sc_inc = 1; step();
      bif.bus = 8'h02; bif.ld_ar = 1; step();
      bif.bus = 8'h11; bif.mem_wr = 1; step();
      check("pre_ac", bif.ac, 8'h5A);
      check("pre_sc", bif.sc, 3);
      check("pre_t", bif.t, 8'h08);
      check("pre_ram2", bif.ram_q, 8'h11);
      #2 rst_n = 1'b0;
      #1;
      check("arst_ac", bif.ac, 0);
      check("arst_sc", bif.sc, 0);
      check("arst_t", bif.t, 8'h01);
      #1 rst_n = 1'b1;
      bif.bus = 8'h02; bif.ld_ar = 1; step();
      check("arst_ram2", bif.ram_q, 0);

      // Bus truncation plus multi-load
      bif.bus = 8'h3C; bif.ld_ac = 1; step();
      bif.bus = 8'hA7; bif.ld_ar = 1; bif.ld_pc = 1; bif.ld_dr = 1; bif.ld_ir = 1; step();
      check("ml_ar", bif.ar, 4'h7);
      check("ml_pc", bif.pc, 4'h7);
      check("ml_dr", bif.dr, 8'hA7);
      check("ml_ir", bif.ir, 8'hA7);
      check("ml_ac", bif.ac, 8'h3C);

      // Priority and wrap
      bif.bus = 8'h0F; bif.ld_pc = 1; step();
      bif.inc_pc = 1; step();
      check("pc_wrap", bif.pc, 0);
      bif.bus = 8'h03; bif.ld_pc = 1; bif.inc_pc = 1; step();
      check("pc_ld_over_inc", bif.pc, 3);
      bif.bus = 8'h44; bif.clr_ac = 1; bif.ld_ac = 1; bif.inc_ac = 1; step();
      check("ac_clr_first", bif.ac, 0);
      bif.bus = 8'hFF; bif.ld_ac = 1; step();
      bif.inc_ac = 1; step();
      check("ac_wrap", bif.ac, 8'h00);
      bif.bus = 8'hFF; bif.ld_dr = 1; step();
      bif.inc_dr = 1; step();
      check("dr_wrap", bif.dr, 8'h00);
      bif.bus = 8'h0F; bif.ld_ar = 1; step();
      bif.inc_ar = 1; step();
      check("ar_wrap", bif.ar, 0);
      bif.bus = 8'h09; bif.clr_ar = 1; bif.ld_ar = 1; step();
      check("ar_clr_first", bif.ar, 0);
      bif.clr_pc = 1; bif.inc_pc = 1; step();
      check("pc_clr_first", bif.pc, 0);
      bif.inc_ac = 1; step();
      check("ac_inc", bif.ac, 8'h01);

      // RAM write with AR change
      bif.bus = 8'h05; bif.ld_ar = 1; step();
      bif.bus = 8'hC3; bif.mem_wr = 1; bif.inc_ar = 1;
      #1 check("rdw_old", bif.ram_q, 0);
      step();
      check("wr_ar", bif.ar, 6);
      check("wr_ram6", bif.ram_q, 0);
      bif.bus = 8'h05; bif.ld_ar = 1; step();
      check("wr_ram5", bif.ram_q, 8'hC3);

      // Fetch sequence from pc = 2 with RAM[2] = 9B
      bif.bus = 8'h02; bif.ld_ar = 1; bif.ld_pc = 1; bif.sc_clr = 1; step();
      bif.bus = 8'h9B; bif.mem_wr = 1; step();
      bif.bus = 8'h00; bif.ld_ar = 1; step();
      check("f_t0", bif.t, 8'h01);
      bif.bus = {4'h0, bif.pc}; bif.ld_ar = 1; bif.sc_inc = 1; step();
      check("f_t1", bif.t, 8'h02);
      check("f_ar", bif.ar, 2);
      bif.bus = bif.ram_q; bif.ld_ir = 1; bif.inc_pc = 1; bif.sc_inc = 1; step();
      check("f_t2", bif.t, 8'h04);
      bif.sc_clr = 1; step();
      check("f_ir", bif.ir, 8'h9B);
      check("f_pc", bif.pc, 3);
      check("f_sc", bif.sc, 0);
      check("f_t_back", bif.t, 8'h01);

      // SC wrap
      for (int i = 1; i <= 8; i++) begin
         bif.sc_inc = 1; step();
         check("sc_step", bif.sc, i % 8);
         check("t_step", bif.t, 32'(1) << (i % 8));
         check("t_onehot", 32'($onehot(bif.t)), 1);
      end
      bif.sc_inc = 1; step();
      check("sc_one", bif.sc, 1);
      bif.sc_inc = 1; bif.sc_clr = 1; step();
      check("sc_clr_first", bif.sc, 0);
      check("sc_clr_t", bif.t, 8'h01);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
